// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with terminal-count pulse and auto-reload
module countdown_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             reload,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc,
  output logic             running
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] reload_reg;

  assign zero    = (count == '0);
  assign running = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      reload_reg <= '0;
      state      <= IDLE;
      tc         <= 1'b0;
    end else if (load) begin
      // A zero load parks the timer in DONE so RUN never holds a zero count
      count      <= load_value;
      reload_reg <= load_value;
      state      <= (load_value != '0) ? RUN : DONE;
      tc         <= 1'b0;
    end else begin
      tc <= 1'b0;
      case (state)
        RUN: begin
          if (enable) begin
            if (count == ONE) begin
              tc <= 1'b1;
              if (reload) begin
                count <= reload_reg;
              end else begin
                count <= '0;
                state <= DONE;
              end
            end else begin
              count <= count - ONE;
            end
          end
        end
        IDLE, DONE: begin
          state <= state;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with terminal-count detection and optional auto-reload. It is the counting-down counterpart of the team's up-counter and shares the same clock, reset and enable conventions. Software-style control logic loads a start value, and the block decrements on each enabled cycle. It flags terminal count as a one-cycle pulse and either stops or reloads the stored value. It sits beside `counter` wherever the design needs timeouts, delays or periodic ticks.

## Interface
- WIDTH, 3, counter and load-value width in bits (≥1)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; sampled on rising clk
- enable  in  1  count gate; decrement permitted only when high
- load  in  1  load strobe; captures load_value on the rising edge where high
- load_value  in  WIDTH  start value, unsigned
- reload  in  1  auto-reload mode select, sampled each cycle
- count  out  WIDTH  current count, registered
- zero  out  1  high when count == 0 (decoded from register, no extra delay)
- tc  out  1  terminal-count pulse, registered, one cycle wide
- running  out  1  high while state == RUN

## Operation
- Three states: IDLE, RUN, DONE. A stored reload register (WIDTH bits) is loaded only by `load`.
- Priority per edge: reset > load > count/decrement.
- reset: count=0, reload register=0, state=IDLE, tc=0. Derived outputs: running=0, zero=1.
- load (any state):
  - Nonzero load_value: count=load_value, reload register=load_value, state=RUN, tc=0.
  - load_value==0: count=0, reload register=0, state=DONE, tc=0.
- IDLE and DONE: count holds and tc=0. enable is ignored.
- RUN, enable=0: count holds, tc=0.
- RUN, enable=1:
  - count > 1: count=count-1, tc=0.
  - count == 1 and reload=0: count=0, state=DONE, tc=1.
  - count == 1 and reload=1: count=reload register, state stays RUN, tc=1. count never shows 0 in this mode.
- Arithmetic is unsigned WIDTH-bit. The decrement never wraps because count==0 is unreachable in RUN. Maximum load value is 2^WIDTH-1.
- tc is 0 on every edge not listed above, so it is never high for two consecutive cycles unless the reload value is 1.
  - With reload value 1 and reload=1 under continuous enable, tc stays high every cycle and count stays 1.

## Timing
- All registered outputs change only on rising clk. zero and running are combinational decodes of registers and settle in the same cycle.
- Load-to-count latency is 1 edge: count shows load_value in the cycle after the load edge.
- A decrement is visible 1 edge after the enabled edge.
- tc is high in exactly the cycle in which count first shows its post-terminal value: 0, or the reload value.
- Simultaneous events:
  - load and terminal decrement on the same edge: load wins, tc=0.
  - reset and load on the same edge: reset wins, load is lost.
- Reset mid-operation: takes effect on the next edge regardless of state. No residual tc.
- Toggling reload while counting affects only the next terminal event.

## Test plan
- Reset only: hold reset 2 cycles, release → count=0, zero=1, running=0, tc=0. enable=1 for 5 cycles with no load → count stays 0.
- One-shot: load 5 with reload=0 and enable held high → count 5,4,3,2,1,0 on successive edges, tc=1 only in the count=0 cycle, running falls with it. Count then holds 0 for 4 further cycles.
- Enable gating: load 4, then the enable sequence 1,1,0,0,0,1,1 → count 4,3,2,2,2,2,1,0, with tc only at the final 0.
- Auto-reload: load 3 with reload=1, enable high for 9 edges → count 2,1,3,2,1,3,2,1,3. tc is high in each cycle count shows 3 after a reload, zero is never high, and running stays 1. Dropping reload before the next 1→terminal edge → count goes to 0 and state becomes DONE.
- Boundaries:
  - count=1, enable=1, load=1, load_value=6 → count=6, tc=0.
  - load 7 (max) → count=7.
  - load 0 → count=0, running=0, tc=0.
- Reset mid-run: at count=3 assert reset together with load=1 and load_value=5 for one edge → count=0, IDLE state, tc=0. The load is ignored and no later tc occurs.
